// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory port bundle
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            if_err;

    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_be;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [DW-1:0]   ls_rdata;
    logic            ls_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
               ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
               ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter_fetch_starve_guard.sv
// rtl/mem_port_arbiter_fetch_starve_guard.sv - load/store-first select with bounded fetch starvation
module fetch_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant_en,
    output logic sel_if,
    output logic sel_ls
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          if_prio;

    always_comb begin
        if_prio  = (streak_q == SW'(MAX_DATA_STREAK));
        sel_if   = grant_en && if_req && (!ls_req || if_prio);
        sel_ls   = grant_en && ls_req && !sel_if;
        streak_d = streak_q;
        // The streak only counts load/store wins that actually made fetch wait.
        if (sel_if) begin
            streak_d = '0;
        end else if (sel_ls) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (!if_prio) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW              = DEF_AW,
    parameter int DW              = DEF_DW,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int BW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            sel_if;
    logic            sel_ls;
    logic            expired;
    logic            rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            mem_req_c;
    logic            live_rsp;

    fetch_starve_guard #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_guard (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .ls_req   (bus.ls_req),
        .grant_en ((state_q == IDLE) && !rst),
        .sel_if   (sel_if),
        .sel_ls   (sel_ls)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        tmo_d     = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        mem_req_c = 1'b0;
        expired   = (tmo_q == TW'(TIMEOUT));

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (sel_if) begin
                    state_d = ISSUE;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    be_d    = '1;
                end else if (sel_ls) begin
                    state_d = ISSUE;
                    owner_d = OWN_LS;
                    we_d    = bus.ls_we;
                    addr_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                    be_d    = bus.ls_be;
                end
            end
            ISSUE: begin
                // An expiring request is withdrawn even if memory accepts it this cycle.
                if (expired) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    mem_req_c = 1'b1;
                    if (bus.mem_gnt) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = bus.mem_rdata;
                    state_d   = IDLE;
                end else if (expired) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            tmo_q   <= tmo_d;
        end
    end

    assign live_rsp      = rsp_valid && !rst;
    assign bus.if_gnt    = sel_if;
    assign bus.ls_gnt    = sel_ls;
    assign bus.if_rvalid = live_rsp && (owner_q == OWN_IF);
    assign bus.ls_rvalid = live_rsp && (owner_q == OWN_LS);
    assign bus.if_err    = bus.if_rvalid && rsp_err;
    assign bus.ls_err    = bus.ls_rvalid && rsp_err;
    assign bus.if_rdata  = bus.if_rvalid ? rsp_data : '0;
    assign bus.ls_rdata  = bus.ls_rvalid ? rsp_data : '0;
    assign bus.mem_req   = mem_req_c && !rst;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        own;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    rsp_t sb[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW              (32),
        .DW              (32),
        .MAX_DATA_STREAK (4),
        .TIMEOUT         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own, input logic [31:0] data, input logic err);
        rsp_t e;
        e.own  = own;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic check_resp();
        rsp_t e;
        if (bus.if_rvalid || bus.ls_rvalid) begin
            chk("rsp_single_owner", 32'(bus.if_rvalid && bus.ls_rvalid), 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected observed=%0d%0d expected=none", bus.if_rvalid, bus.ls_rvalid);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_owner", 32'(bus.ls_rvalid), 32'(e.own));
                chk("rsp_data", bus.ls_rvalid ? bus.ls_rdata : bus.if_rdata, e.data);
                chk("rsp_err", 32'(bus.ls_rvalid ? bus.ls_err : bus.if_err), 32'(e.err));
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_resp();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
                 bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata, bus.ls_err,
                 bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be};
    endfunction

    initial begin
        logic exp_if;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_be = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        adv(); adv();
        rst = 1'b0;
        sample();
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        adv();

        // single fetch, minimum latency
        bus.if_req = 1; bus.if_addr = 32'h100;
        sample();
        chk("fetch_if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("fetch_ls_gnt", 32'(bus.ls_gnt), 32'd0);
        push(1'b0, 32'hDEADBEEF, 1'b0);
        adv();
        bus.if_req = 0; bus.mem_gnt = 1;
        sample();
        chk("fetch_mem_req", 32'(bus.mem_req), 32'd1);
        chk("fetch_mem_addr", bus.mem_addr, 32'h100);
        chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        chk("fetch_mem_be", 32'(bus.mem_be), 32'hF);
        adv();
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
        sample();
        chk("fetch_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        adv();
        bus.mem_rvalid = 0;

        // store acknowledge with a delayed mem_gnt
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h2000; bus.ls_wdata = 32'h12345678; bus.ls_be = 4'hF;
        sample();
        chk("store_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("store_if_gnt", 32'(bus.if_gnt), 32'd0);
        push(1'b1, 32'hCAFE0000, 1'b0);
        adv();
        bus.ls_req = 0;
        sample();
        chk("store_mem_req", 32'(bus.mem_req), 32'd1);
        chk("store_mem_we", 32'(bus.mem_we), 32'd1);
        chk("store_mem_addr", bus.mem_addr, 32'h2000);
        chk("store_mem_wdata", bus.mem_wdata, 32'h12345678);
        chk("store_mem_be", 32'(bus.mem_be), 32'hF);
        adv();
        bus.mem_gnt = 1;
        sample();
        chk("store_req_held", 32'(bus.mem_req), 32'd1);
        adv();
        bus.mem_gnt = 0;
        sample();
        chk("store_wait_no_req", 32'(bus.mem_req), 32'd0);
        adv();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE0000;
        sample();
        chk("store_if_rvalid_low", 32'(bus.if_rvalid), 32'd0);
        adv();
        bus.mem_rvalid = 0;

        // both requesters held: fetch wins after four load/store grants
        bus.if_req = 1; bus.if_addr = 32'h400;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h3000;
        for (int g = 0; g < 10; g++) begin
            exp_if = (g == 4) || (g == 9);
            sample();
            chk($sformatf("starve_if_gnt_%0d", g), 32'(bus.if_gnt), 32'(exp_if));
            chk($sformatf("starve_ls_gnt_%0d", g), 32'(bus.ls_gnt), 32'(!exp_if));
            push(!exp_if, 32'h1000 + 32'(g), 1'b0);
            adv();
            bus.mem_gnt = 1;
            sample();
            chk("starve_mem_addr", bus.mem_addr, exp_if ? 32'h400 : 32'h3000);
            chk("starve_no_gnt_busy", 32'(bus.if_gnt || bus.ls_gnt), 32'd0);
            adv();
            bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1000 + 32'(g);
            sample();
            adv();
            bus.mem_rvalid = 0;
        end
        bus.if_req = 0; bus.ls_req = 0;

        // fetch timeout in WAIT, then a stale response two cycles later
        bus.if_req = 1; bus.if_addr = 32'h500;
        sample();
        chk("tmo_if_gnt", 32'(bus.if_gnt), 32'd1);
        push(1'b0, 32'h0, 1'b1);
        adv();
        bus.if_req = 0;
        for (int k = 1; k <= 11; k++) begin
            bus.mem_gnt    = (k == 1);
            bus.mem_rvalid = (k == 11);
            bus.mem_rdata  = 32'h77;
            sample();
            chk($sformatf("tmo_if_rvalid_c%0d", k), 32'(bus.if_rvalid), 32'(k == 9));
            adv();
        end
        bus.mem_rvalid = 0;

        // mem_gnt on the expiry cycle of ISSUE: the timeout wins
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h3100;
        sample();
        chk("tmo2_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        push(1'b1, 32'h0, 1'b1);
        adv();
        bus.ls_req = 0;
        for (int k = 1; k <= 9; k++) begin
            bus.mem_gnt = (k == 9);
            sample();
            chk($sformatf("tmo2_mem_req_c%0d", k), 32'(bus.mem_req), 32'(k != 9));
            chk($sformatf("tmo2_ls_rvalid_c%0d", k), 32'(bus.ls_rvalid), 32'(k == 9));
            adv();
        end
        bus.mem_gnt = 0;

        // mem_rvalid on the expiry cycle of WAIT: the response wins
        bus.if_req = 1; bus.if_addr = 32'h700;
        sample();
        push(1'b0, 32'hABCD, 1'b0);
        adv();
        bus.if_req = 0;
        for (int k = 1; k <= 9; k++) begin
            bus.mem_gnt    = (k == 1);
            bus.mem_rvalid = (k == 9);
            bus.mem_rdata  = 32'hABCD;
            sample();
            chk($sformatf("race_if_rvalid_c%0d", k), 32'(bus.if_rvalid), 32'(k == 9));
            adv();
        end
        bus.mem_rvalid = 0;

        // reset while in WAIT abandons the transaction
        bus.if_req = 1; bus.if_addr = 32'h800;
        sample();
        adv();
        bus.if_req = 0; bus.mem_gnt = 1;
        sample();
        adv();
        bus.mem_gnt = 0; rst = 1;
        sample();
        chk("rstwait_no_rvalid", 32'(bus.if_rvalid || bus.ls_rvalid), 32'd0);
        adv();
        rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0;
        sample();
        chk("rstwait_outputs_zero", 32'(any_out()), 32'd0);
        adv();
        bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h600;
        sample();
        chk("rstwait_new_gnt", 32'(bus.if_gnt), 32'd1);
        push(1'b0, 32'h600D, 1'b0);
        adv();
        bus.if_req = 0; bus.mem_gnt = 1;
        sample();
        chk("rstwait_mem_addr", bus.mem_addr, 32'h600);
        adv();
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h600D;
        sample();
        adv();
        bus.mem_rvalid = 0;
        sample();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the load/store requester of the RISC-V core. It holds one outstanding transaction, routes the response to its owner, prevents fetch starvation under load/store bursts, and terminates hung transactions with an error. It sits between the core's fetch/LSU logic and the memory.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 bits
- MAX_DATA_STREAK, 4, consecutive load/store grants allowed while fetch waits
- TIMEOUT, 255, cycles from ISSUE entry before a transaction is aborted with an error
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous and active-high.
- if_req  in  1  fetch request; if_addr is held stable until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted; one-cycle pulse
- if_rvalid  out  1  fetch response; one-cycle pulse
- if_rdata  out  DW  fetch data; valid with if_rvalid
- if_err  out  1  fetch timed out; valid with if_rvalid
- ls_req  in  1  load/store request; payload held stable until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_be  in  DW/8  store byte enables
- ls_gnt, ls_rvalid, ls_rdata, ls_err  out  1/1/DW/1  same meaning as the if_* outputs; stores also receive an ls_rvalid acknowledge
- mem_req  out  1  memory request; held until mem_gnt
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  latched payload
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response; arrives at least 1 cycle after mem_gnt
- mem_rdata  in  DW  read data; don't-care for stores

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any request is present, select a winner. if_gnt or ls_gnt is asserted combinationally in the same cycle. The winner's payload and owner are latched (fetch: we=0, be=all ones, wdata=0). Next state is ISSUE. With no request, the block stays in IDLE.
- Priority: ls wins by default. if wins when both request and streak == MAX_DATA_STREAK.
- Streak counter (0..MAX_DATA_STREAK):
  - Incremented on an ls grant while if_req=1.
  - Cleared on an if grant.
  - Cleared on an ls grant while if_req=0.
- ISSUE: mem_req=1 with the latched payload. On mem_gnt, next state is WAIT.
- WAIT: mem_rvalid produces a combinational pass-through to the owner: owner_rvalid=1, owner_rdata=mem_rdata, err=0. Next state is IDLE.
- Timeout: the counter clears on entry to ISSUE and increments every cycle in ISSUE/WAIT. When it reaches TIMEOUT:
  - the owner gets rvalid=1, err=1, rdata=0;
  - mem_req drops;
  - next state is IDLE.
- mem_rvalid is ignored outside WAIT. This covers stale responses after a timeout or a reset.
- The non-owner's rvalid stays 0 at all times.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - streak and timeout counters 0;
  - latched payload 0.
- Reset mid-transaction abandons it: no rvalid is returned, and a late mem_rvalid is dropped.
- Minimum latency:
  - request seen in IDLE at cycle 0 gives gnt at cycle 0;
  - mem_req at cycle 1 (mem_gnt at cycle 1);
  - mem_rvalid at cycle 2 gives owner rvalid at cycle 2;
  - the next grant is possible at cycle 3.
- Peak throughput is one transaction per 3 cycles.
- gnt is never asserted outside IDLE. A requester must keep req high until gnt.
- mem_gnt and timeout expiry in the same ISSUE cycle: timeout wins.
- mem_rvalid and timeout expiry in the same WAIT cycle: the response wins, err=0.
- With TIMEOUT=255, the abort fires exactly 255 cycles after ISSUE entry. The counter width is $clog2(TIMEOUT+1) and it saturates.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - owner enum {OWN_IF, OWN_LS};
  - default AW/DW constants.
- One sub-module, fetch_starve_guard, holds the streak counter and the priority select.
  - Inputs: if_req, ls_req, grant_en.
  - Outputs: sel_if, sel_ls.
- The FSM, payload latch, timeout counter and response routing stay in mem_port_arbiter.

## Test plan
- Single fetch: if_req, addr 0x100 at cycle 0.
  - Expect if_gnt at cycle 0 and mem_req/addr 0x100 at cycle 1.
  - With mem_gnt at cycle 1 and mem_rvalid/rdata 0xDEADBEEF at cycle 2: if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 at cycle 2.
- Store ack: ls_we=1, addr 0x2000, wdata 0x12345678, be 0xF.
  - Expect mem_we=1 with identical payload, ls_rvalid on mem_rvalid, and if_rvalid stays 0.
- Starvation guard: if_req and ls_req held continuously, MAX_DATA_STREAK=4.
  - Expect grant order ls,ls,ls,ls,if,ls,…; the streak resets after the if grant.
- Timeout: mem_gnt given, mem_rvalid withheld, TIMEOUT=8.
  - Expect owner rvalid=1, err=1, rdata=0 exactly 8 cycles after ISSUE entry.
  - A mem_rvalid injected 2 cycles later is ignored.
- Reset mid-WAIT: assert rst for 1 cycle, then pulse mem_rvalid.
  - Expect all outputs 0 and no rvalid to either requester.
  - A new if_req is granted the cycle after rst deasserts.
